object_spawn_arbiter: RTL and testbench

- Shares the collider object slot pool (SLOT_AMOUNT slots, the bits behind object_ready_state) between two spawn requesters: the attack-object reader and the platform-object reader.
- Picks a requester round-robin, allocates the lowest free slot and issues one spawn command to the multi-object collider runtime over a valid/ready handshake.
- Tracks slot occupancy, which is released by destroy events from the runtime.
- Sits between the game runtime's ROM readers and the collider runtime.

---
 rtl/game_object_pkg.sv | 29 ++
 rtl/slot_free_finder.sv | 47 ++++
 rtl/object_spawn_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_object_spawn_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_object_pkg.sv
// ---------------------------------------------------------------------------
// game_object_pkg
//
// Shared definitions for the collider object pool: pool geometry, the
// requester source encoding carried on spawn_src, and the state encoding of
// the spawn arbiter FSM.
// ---------------------------------------------------------------------------
package game_object_pkg;

  // Collider object slot pool geometry.
  localparam int SLOT_AMOUNT = 30;
  localparam int SLOT_W      = 5;
  localparam int IDX_W       = 10;

  // Requester identity as reported on spawn_src.
  localparam logic SRC_ATTACK   = 1'b0;
  localparam logic SRC_PLATFORM = 1'b1;

  // Spawn arbiter FSM.
  //   IDLE  : arbitrate and allocate a slot
  //   ISSUE : spawn command presented to the collider runtime
  //   ACK   : one-cycle acknowledge back to the served requester
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } spawn_state_e;

endpackage

// File: rtl/slot_free_finder.sv
// ---------------------------------------------------------------------------
// slot_free_finder
//
// Purely combinational lowest-zero priority encoder over an occupancy bitmap.
// Also reused by the multi-object trigger runtime.
//
// Ports:
//   busy      in   N      occupancy bitmap, 1 = slot taken
//   slot      out  W      index of the lowest free slot (0 when none free)
//   found     out  1      at least one slot is free
//   free_cnt  out  W+1    number of free slots
// ---------------------------------------------------------------------------
module slot_free_finder #(
  parameter int N = 30,
  parameter int W = 5
) (
  input  logic [N-1:0] busy,
  output logic [W-1:0] slot,
  output logic         found,
  output logic [W:0]   free_cnt
);

  localparam logic [W:0] CNT_ONE = {{W{1'b0}}, 1'b1};

  // Lowest free slot: scan from the top so the last hit is the lowest index.
  always_comb begin
    slot  = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        slot  = W'(i);
        found = 1'b1;
      end
    end
  end

  // Free slot count.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (!busy[i]) begin
        free_cnt = free_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/object_spawn_arbiter.sv
// ---------------------------------------------------------------------------
// object_spawn_arbiter
//
// Shares the collider object slot pool between the attack-object reader and
// the platform-object reader. A requester is chosen round-robin, the lowest
// free slot is reserved, and a single spawn command is issued to the collider
// runtime over a valid/ready handshake. The served requester then receives a
// one-cycle ack. Slots are freed by destroy pulses on release_vec.
//
// Ports:
//   clk          in   1            system clock
//   clk_reset    in   1            asynchronous reset, active low
//   clear        in   1            synchronous stage reset: free all slots,
//                                  abort any spawn in flight
//   atk_req      in   1            attack requester, held until atk_ack
//   atk_idx      in   IDX_W        attack ROM index
//   atk_ack      out  1            attack request served (1-cycle pulse)
//   plt_req      in   1            platform requester, held until plt_ack
//   plt_idx      in   IDX_W        platform ROM index
//   plt_ack      out  1            platform request served (1-cycle pulse)
//   spawn_valid  out  1            spawn command valid
//   spawn_ready  in   1            collider runtime accepts the command
//   spawn_slot   out  SLOT_W       allocated slot
//   spawn_src    out  1            0 = attack, 1 = platform
//   spawn_idx    out  IDX_W        ROM index of the granted request
//   release_vec  in   SLOT_AMOUNT  per-slot destroy pulses
//   busy_vec     out  SLOT_AMOUNT  occupancy bitmap (reserved or occupied)
//   full         out  1            every slot busy
//   free_cnt     out  SLOT_W+1     number of free slots
// ---------------------------------------------------------------------------
module object_spawn_arbiter #(
  parameter int SLOT_AMOUNT = game_object_pkg::SLOT_AMOUNT,
  parameter int SLOT_W      = game_object_pkg::SLOT_W,
  parameter int IDX_W       = game_object_pkg::IDX_W
) (
  input  logic                   clk,
  input  logic                   clk_reset,
  input  logic                   clear,
  input  logic                   atk_req,
  input  logic [IDX_W-1:0]       atk_idx,
  output logic                   atk_ack,
  input  logic                   plt_req,
  input  logic [IDX_W-1:0]       plt_idx,
  output logic                   plt_ack,
  output logic                   spawn_valid,
  input  logic                   spawn_ready,
  output logic [SLOT_W-1:0]      spawn_slot,
  output logic                   spawn_src,
  output logic [IDX_W-1:0]       spawn_idx,
  input  logic [SLOT_AMOUNT-1:0] release_vec,
  output logic [SLOT_AMOUNT-1:0] busy_vec,
  output logic                   full,
  output logic [SLOT_W:0]        free_cnt
);

  import game_object_pkg::*;

  // FSM and arbitration state.
  spawn_state_e            state_q, state_d;
  logic                    last_grant_q, last_grant_d;

  // Slot occupancy.
  logic [SLOT_AMOUNT-1:0]  busy_q, busy_d;

  // Latched spawn command, held stable through ISSUE and ACK.
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic                    src_q, src_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  // Free slot search on the registered bitmap. Because the search looks at
  // busy_q rather than busy_d, a release landing in the grant cycle is only
  // visible to the next arbitration.
  logic [SLOT_W-1:0]       free_slot;
  logic                    free_found;
  logic [SLOT_W:0]         free_count;

  slot_free_finder #(
    .N (SLOT_AMOUNT),
    .W (SLOT_W)
  ) u_slot_free_finder (
    .busy     (busy_q),
    .slot     (free_slot),
    .found    (free_found),
    .free_cnt (free_count)
  );

  // Round-robin choice: on a tie, serve the side that did not win last time.
  logic                    grant_src;
  logic                    grant;
  logic [SLOT_AMOUNT-1:0]  alloc_onehot;

  always_comb begin
    grant_src = SRC_ATTACK;
    if (atk_req && plt_req) begin
      grant_src = ~last_grant_q;
    end else if (plt_req) begin
      grant_src = SRC_PLATFORM;
    end
  end

  // Next-state, allocation and busy bitmap update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    slot_d       = slot_q;
    src_d        = src_q;
    idx_d        = idx_q;
    grant        = 1'b0;

    case (state_q)
      IDLE: begin
        // free_found is the registered !full, so a full pool simply stalls.
        if ((atk_req || plt_req) && free_found) begin
          grant        = 1'b1;
          slot_d       = free_slot;
          src_d        = grant_src;
          idx_d        = (grant_src == SRC_PLATFORM) ? plt_idx : atk_idx;
          last_grant_d = grant_src;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (spawn_ready) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    alloc_onehot = '0;
    for (int i = 0; i < SLOT_AMOUNT; i++) begin
      alloc_onehot[i] = grant && (free_slot == SLOT_W'(i));
    end

    // Releasing an already-free slot is a no-op by construction.
    busy_d = (busy_q & ~release_vec) | alloc_onehot;

    // Stage reset wins over everything but the async reset. The round-robin
    // pointer survives so fairness carries across stages, and an aborted
    // grant does not count as a win.
    if (clear) begin
      state_d      = IDLE;
      busy_d       = '0;
      last_grant_d = last_grant_q;
      slot_d       = slot_q;
      src_d        = src_q;
      idx_d        = idx_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge clk_reset) begin
    if (!clk_reset) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_PLATFORM;
      busy_q       <= '0;
      slot_q       <= '0;
      src_q        <= SRC_ATTACK;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      slot_q       <= slot_d;
      src_q        <= src_d;
      idx_q        <= idx_d;
    end
  end

  // Outputs decode directly from registered state.
  assign spawn_valid = (state_q == ISSUE);
  assign spawn_slot  = slot_q;
  assign spawn_src   = src_q;
  assign spawn_idx   = idx_q;
  assign atk_ack     = (state_q == ACK) && (src_q == SRC_ATTACK);
  assign plt_ack     = (state_q == ACK) && (src_q == SRC_PLATFORM);
  assign busy_vec    = busy_q;
  assign full        = &busy_q;
  assign free_cnt    = free_count;

endmodule

// File: tb/tb_object_spawn_arbiter.sv
module tb_object_spawn_arbiter;
  import game_object_pkg::*;

  localparam int N  = 30;
  localparam int SW = 5;
  localparam int IW = 10;

  logic          clk = 1'b0;
  logic          clk_reset, clear;
  logic          atk_req, plt_req, atk_ack, plt_ack;
  logic [IW-1:0] atk_idx, plt_idx, spawn_idx;
  logic          spawn_valid, spawn_ready, spawn_src, full;
  logic [SW-1:0] spawn_slot;
  logic [N-1:0]  release_vec, busy_vec;
  logic [SW:0]   free_cnt;

  always #5 clk = ~clk;

  object_spawn_arbiter #(.SLOT_AMOUNT(N), .SLOT_W(SW), .IDX_W(IW)) dut (
    .clk(clk), .clk_reset(clk_reset), .clear(clear),
    .atk_req(atk_req), .atk_idx(atk_idx), .atk_ack(atk_ack),
    .plt_req(plt_req), .plt_idx(plt_idx), .plt_ack(plt_ack),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_slot(spawn_slot), .spawn_src(spawn_src), .spawn_idx(spawn_idx),
    .release_vec(release_vec), .busy_vec(busy_vec), .full(full),
    .free_cnt(free_cnt)
  );

  typedef struct {
    logic [SW-1:0] slot;
    logic          src;
    logic [IW-1:0] idx;
  } exp_t;

  typedef struct {
    logic          a;
    logic          p;
    logic [IW-1:0] ai;
    logic [IW-1:0] pi;
    logic [SW-1:0] slot;
    logic          src;
    logic [IW-1:0] idx;
  } vec_t;

  exp_t         sb[$];
  vec_t         tbl[4];
  int           n_pass = 0;
  int           n_total = 0;
  logic [N-1:0] m_busy;
  logic         m_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  function automatic int m_low();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction

  // Expected grant from the bench's own round-robin / lowest-free model.
  task automatic push_model(input logic a, input logic p,
                            input logic [IW-1:0] ai, input logic [IW-1:0] pi);
    exp_t e;
    logic s;
    s      = (a && p) ? ~m_last : p;
    e.slot = SW'(m_low());
    e.src  = s;
    e.idx  = s ? pi : ai;
    sb.push_back(e);
  endtask

  // Waits (bounded) for a handshake, compares it against the scoreboard,
  // then checks the ack in the following cycle and drops both requests.
  task automatic wait_handshake(input string nm);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (spawn_valid && spawn_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s_sb: got empty queue, want an expected entry", nm);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_handshake"}, 64'(ok), 64'd1);
    if (!ok) begin
      atk_req = 1'b0;
      plt_req = 1'b0;
      return;
    end
    chk({nm, "_slot"}, 64'(spawn_slot), 64'(e.slot));
    chk({nm, "_src"},  64'(spawn_src),  64'(e.src));
    chk({nm, "_idx"},  64'(spawn_idx),  64'(e.idx));
    @(negedge clk);
    chk({nm, "_ack"}, 64'({spawn_valid, atk_ack, plt_ack}),
        e.src ? 64'b001 : 64'b010);
    atk_req   = 1'b0;
    plt_req   = 1'b0;
    m_busy[e.slot] = 1'b1;
    m_last    = e.src;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_valid"}, 64'(spawn_valid), 64'd0);
    chk({nm, "_cmd"},   64'({spawn_slot, spawn_src, spawn_idx}), 64'd0);
    chk({nm, "_acks"},  64'({atk_ack, plt_ack}), 64'd0);
    chk({nm, "_busy"},  64'(busy_vec), 64'd0);
    chk({nm, "_full"},  64'(full), 64'd0);
    chk({nm, "_free"},  64'(free_cnt), 64'd30);
  endtask

  task automatic do_reset();
    clk_reset   = 1'b0;
    clear       = 1'b0;
    atk_req     = 1'b0;
    plt_req     = 1'b0;
    atk_idx     = '0;
    plt_idx     = '0;
    spawn_ready = 1'b1;
    release_vec = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    check_reset("reset");
    clk_reset = 1'b1;
    m_busy    = '0;
    m_last    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] cap_slot;
    logic          cap_src;
    logic [IW-1:0] cap_idx;
    bit            bad;
    exp_t          e;
    int            guard;

    tbl[0] = '{1'b1, 1'b1, 10'd3, 10'd7, 5'd0, 1'b0, 10'd3};
    tbl[1] = '{1'b1, 1'b1, 10'd3, 10'd7, 5'd1, 1'b1, 10'd7};
    tbl[2] = '{1'b1, 1'b1, 10'd3, 10'd7, 5'd2, 1'b0, 10'd3};
    tbl[3] = '{1'b1, 1'b1, 10'd3, 10'd7, 5'd3, 1'b1, 10'd7};

    // Single attack request straight after reset.
    do_reset();
    push_model(1'b1, 1'b0, 10'd12, 10'd0);
    atk_req = 1'b1;
    atk_idx = 10'd12;
    @(negedge clk);
    chk("t1_latency", 64'(spawn_valid), 64'd1);
    wait_handshake("t1");
    chk("t1_busy", 64'(busy_vec), 64'h1);
    chk("t1_free", 64'(free_cnt), 64'd29);

    // Both requesters held: alternating grants.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e.slot = tbl[i].slot;
      e.src  = tbl[i].src;
      e.idx  = tbl[i].idx;
      sb.push_back(e);
      atk_req = tbl[i].a;
      plt_req = tbl[i].p;
      atk_idx = tbl[i].ai;
      plt_idx = tbl[i].pi;
      @(negedge clk);
      wait_handshake($sformatf("vec%0d", i));
    end
    chk("rr_busy", 64'(busy_vec), 64'h0F);

    // Grant and release in the same cycle.
    @(negedge clk);
    atk_req     = 1'b1;
    atk_idx     = 10'd20;
    release_vec = 30'h4;
    e.slot = 5'd4; e.src = 1'b0; e.idx = 10'd20;
    sb.push_back(e);
    @(negedge clk);
    release_vec = '0;
    m_busy[2]   = 1'b0;
    chk("same_cycle_busy", 64'(busy_vec), 64'h1B);
    wait_handshake("same_cycle");

    // spawn_ready held low in ISSUE.
    @(negedge clk);
    spawn_ready = 1'b0;
    plt_req     = 1'b1;
    plt_idx     = 10'd9;
    push_model(1'b0, 1'b1, 10'd0, 10'd9);
    @(negedge clk);
    chk("ready_low_valid", 64'(spawn_valid), 64'd1);
    cap_slot = spawn_slot; cap_src = spawn_src; cap_idx = spawn_idx;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (!spawn_valid || spawn_slot !== cap_slot || spawn_src !== cap_src ||
          spawn_idx !== cap_idx || atk_ack || plt_ack) bad = 1'b1;
    end
    chk("ready_low_hold", 64'(bad), 64'd0);
    spawn_ready = 1'b1;
    wait_handshake("ready_low");

    // Fill the pool.
    guard = 0;
    while (m_busy != '1 && guard < 40) begin
      push_model(1'b1, 1'b0, IW'(100 + guard), 10'd0);
      atk_req = 1'b1;
      atk_idx = IW'(100 + guard);
      @(negedge clk);
      wait_handshake("fill");
      guard++;
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_free", 64'(free_cnt), 64'd0);
    chk("fill_busy", 64'(busy_vec), 64'h3FFF_FFFF);

    // Request against a full pool, then free slot 17.
    plt_req = 1'b1;
    plt_idx = 10'h3FF;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (spawn_valid || atk_ack || plt_ack) bad = 1'b1;
    end
    chk("full_no_grant", 64'(bad), 64'd0);
    release_vec = 30'h1 << 17;
    @(negedge clk);
    release_vec = '0;
    chk("release_full", 64'(full), 64'd0);
    chk("release_free", 64'(free_cnt), 64'd1);
    m_busy[17] = 1'b0;
    push_model(1'b0, 1'b1, 10'd0, 10'h3FF);
    wait_handshake("refill");
    chk("refill_full", 64'(full), 64'd1);

    // clear during ISSUE, then re-serve.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_model(1'b1, 1'b0, IW'(k), 10'd0);
      atk_req = 1'b1;
      atk_idx = IW'(k);
      @(negedge clk);
      wait_handshake("pre_clear");
    end
    @(negedge clk);
    spawn_ready = 1'b0;
    atk_req     = 1'b1;
    atk_idx     = 10'd55;
    @(negedge clk);
    chk("clr_issue_valid", 64'(spawn_valid), 64'd1);
    chk("clr_issue_busy", 64'(busy_vec), 64'h7F);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_busy", 64'(busy_vec), 64'd0);
    chk("clr_out", 64'({spawn_valid, atk_ack, plt_ack}), 64'd0);
    m_busy = '0;
    spawn_ready = 1'b1;
    push_model(1'b1, 1'b0, 10'd55, 10'd0);
    @(negedge clk);
    wait_handshake("post_clear");

    // Asynchronous reset in the middle of ISSUE.
    @(negedge clk);
    spawn_ready = 1'b0;
    plt_req     = 1'b1;
    plt_idx     = 10'd42;
    @(negedge clk);
    chk("async_pre_valid", 64'(spawn_valid), 64'd1);
    #2 clk_reset = 1'b0;
    #1 check_reset("async");
    @(negedge clk);
    plt_req     = 1'b0;
    spawn_ready = 1'b1;
    clk_reset   = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
